enigma_key_sequencer: RTL and testbench

Per-keypress controller for the Enigma datapath. It sits between the keyboard decoder and the rotor/reflector block. For each key it steps the three rotor positions with notch and double-step rules, passes the key through the programmable plugboard, and drives the rotor/reflector input for a fixed settle window. It then passes the return path through the plugboard again and presents a registered cipher letter to the GUI. It also owns plugboard pair programming, replacing the free-running combinational plugboard.

---
 rtl/enigma_pkg.sv | 55 +++++
 rtl/enigma_key_sequencer_plug_table.sv | 67 ++++++
 rtl/enigma_key_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_enigma_key_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared types and letter helpers for the Enigma key sequencer.
// A letter is a 5-bit index (A=0 .. Z=25) or a 26-bit one-hot vector.
package enigma_pkg;

    localparam int LETTERS = 26;

    typedef logic [4:0]         letter_t;
    typedef logic [LETTERS-1:0] onehot_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STEP    = 3'd1,
        DRIVE   = 3'd2,
        CAPTURE = 3'd3,
        PROG_A  = 3'd4,
        PROG_B  = 3'd5
    } state_t;

    localparam int      DEF_NUM_PAIRS     = 10;
    localparam int      DEF_SETTLE_CYCLES = 4;
    localparam letter_t DEF_NOTCH1        = 5'd16;
    localparam letter_t DEF_NOTCH2        = 5'd4;

    function automatic onehot_t to_onehot(input letter_t idx);
        onehot_t oh;
        for (int i = 0; i < LETTERS; i++) begin
            oh[i] = (idx == letter_t'(i));
        end
        return oh;
    endfunction

    function automatic letter_t to_index(input onehot_t oh);
        letter_t idx;
        idx = '0;
        for (int i = 0; i < LETTERS; i++) begin
            if (oh[i]) begin
                idx = idx | letter_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input onehot_t oh);
        return (oh != '0) && ((oh & (oh - onehot_t'(1))) == '0);
    endfunction

    function automatic letter_t wrap_inc(input letter_t x);
        return (x == 5'd25) ? 5'd0 : x + 5'd1;
    endfunction

    function automatic letter_t mod26(input letter_t x);
        return (x > 5'd25) ? x - 5'd26 : x;
    endfunction

endpackage

// File: rtl/enigma_key_sequencer_plug_table.sv
// Plugboard pair storage with combinational swap lookups for the forward
// key and the return path, plus an occupancy check for incoming keys.
module plug_table
    import enigma_pkg::*;
#(
    parameter int NUM_PAIRS = DEF_NUM_PAIRS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [4:0] wr_a,
    input  logic [4:0] wr_b,
    input  logic [4:0] fwd_in,
    output logic [4:0] fwd_out,
    input  logic [4:0] ret_in,
    output logic [4:0] ret_out,
    input  logic [4:0] chk_in,
    output logic       chk_plugged,
    output logic [3:0] pair_count,
    output logic       full
);

    logic [4:0] tab_a [NUM_PAIRS];
    logic [4:0] tab_b [NUM_PAIRS];
    logic [3:0] count;

    assign pair_count = count;
    assign full       = (count == 4'(NUM_PAIRS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < NUM_PAIRS; i++) begin
                tab_a[i] <= '0;
                tab_b[i] <= '0;
            end
        end else if (clear) begin
            count <= '0;
        end else if (wr_en && !full) begin
            for (int i = 0; i < NUM_PAIRS; i++) begin
                if (count == 4'(i)) begin
                    tab_a[i] <= wr_a;
                    tab_b[i] <= wr_b;
                end
            end
            count <= count + 4'd1;
        end
    end

    // Only the first pair_count entries are live; stale entries are ignored.
    always_comb begin
        fwd_out     = fwd_in;
        ret_out     = ret_in;
        chk_plugged = 1'b0;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (4'(i) < count) begin
                if (tab_a[i] == fwd_in) fwd_out = tab_b[i];
                else if (tab_b[i] == fwd_in) fwd_out = tab_a[i];
                if (tab_a[i] == ret_in) ret_out = tab_b[i];
                else if (tab_b[i] == ret_in) ret_out = tab_a[i];
                if ((tab_a[i] == chk_in) || (tab_b[i] == chk_in)) chk_plugged = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enigma_key_sequencer.sv
// Per-keypress Enigma controller: rotor stepping, plugboard in/out,
// rotor/reflector settle window and plugboard pair programming.
//   state   | meaning
//   IDLE    | wait for key, pos_load or prog_mode
//   STEP    | advance rotors (notch / double-step)
//   DRIVE   | hold rero_in for SETTLE_CYCLES
//   CAPTURE | sample rero_out, register cipher letter
//   PROG_A  | wait for first letter of a pair
//   PROG_B  | wait for second letter of a pair
module enigma_key_sequencer
    import enigma_pkg::*;
#(
    parameter int         NUM_PAIRS     = DEF_NUM_PAIRS,
    parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [4:0] NOTCH1        = DEF_NOTCH1,
    parameter logic [4:0] NOTCH2        = DEF_NOTCH2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [25:0] key_onehot,
    input  logic        prog_mode,
    input  logic        pos_load,
    input  logic [14:0] pos_init,
    output logic [25:0] rero_in,
    input  logic [25:0] rero_out,
    output logic [4:0]  state1,
    output logic [4:0]  state2,
    output logic [4:0]  state3,
    output logic [25:0] cipher_out,
    output logic        cipher_valid,
    output logic        busy,
    output logic [3:0]  pair_count,
    output logic        err
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t     state, state_nxt;
    letter_t    key_idx;
    logic [CNT_W-1:0] settle_cnt;

    logic    key_ok, ret_ok, plugged, full;
    letter_t key_in_idx, ret_idx, plug_fwd, plug_ret;

    logic latch_key, clear_tab, wr_pair, err_nxt, load_pos, do_step, capture;

    assign key_ok     = is_onehot(key_onehot);
    assign key_in_idx = to_index(key_onehot);
    assign ret_ok     = is_onehot(rero_out);
    assign ret_idx    = to_index(rero_out);

    plug_table #(.NUM_PAIRS(NUM_PAIRS)) u_plug (
        .clk         (CLOCK_50),
        .rst         (reset),
        .clear       (clear_tab),
        .wr_en       (wr_pair),
        .wr_a        (key_idx),
        .wr_b        (key_in_idx),
        .fwd_in      (key_idx),
        .fwd_out     (plug_fwd),
        .ret_in      (ret_idx),
        .ret_out     (plug_ret),
        .chk_in      (key_in_idx),
        .chk_plugged (plugged),
        .pair_count  (pair_count),
        .full        (full)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (prog_mode)                 state_nxt = PROG_A;
                else if (pos_load)             state_nxt = IDLE;
                else if (key_valid && key_ok)  state_nxt = STEP;
            end
            STEP:    state_nxt = DRIVE;
            DRIVE:   if (settle_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            PROG_A: begin
                if (!prog_mode) state_nxt = IDLE;
                else if (key_valid && key_ok && !plugged && !full) state_nxt = PROG_B;
            end
            PROG_B: begin
                if (!prog_mode)     state_nxt = IDLE;
                else if (key_valid) state_nxt = PROG_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        rero_in   = '0;
        latch_key = 1'b0;
        clear_tab = 1'b0;
        wr_pair   = 1'b0;
        err_nxt   = 1'b0;
        load_pos  = 1'b0;
        do_step   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                clear_tab = prog_mode;
                load_pos  = !prog_mode && pos_load;
                latch_key = !prog_mode && !pos_load && key_valid && key_ok;
                err_nxt   = key_valid && (prog_mode || pos_load || !key_ok);
            end
            STEP: begin
                busy    = 1'b1;
                do_step = 1'b1;
                err_nxt = key_valid;
            end
            DRIVE: begin
                busy    = 1'b1;
                rero_in = to_onehot(plug_fwd);
                err_nxt = key_valid;
            end
            CAPTURE: begin
                busy    = 1'b1;
                rero_in = to_onehot(plug_fwd);
                capture = 1'b1;
                err_nxt = key_valid || !ret_ok;
            end
            PROG_A: begin
                if (key_valid) begin
                    if (prog_mode && key_ok && !plugged && !full) latch_key = 1'b1;
                    else                                          err_nxt   = 1'b1;
                end
            end
            PROG_B: begin
                if (key_valid) begin
                    if (prog_mode && key_ok && !plugged && (key_in_idx != key_idx)) wr_pair = 1'b1;
                    else                                                              err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_idx      <= '0;
            settle_cnt   <= '0;
            state1       <= '0;
            state2       <= '0;
            state3       <= '0;
            cipher_out   <= '0;
            cipher_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            err          <= err_nxt;
            cipher_valid <= capture;
            if (latch_key) key_idx <= key_in_idx;
            if (load_pos) begin
                state1 <= mod26(pos_init[4:0]);
                state2 <= mod26(pos_init[9:5]);
                state3 <= mod26(pos_init[14:10]);
            end
            // Notch tests use pre-step positions; rotor 2 at its notch double-steps.
            if (do_step) begin
                state1 <= wrap_inc(state1);
                if (state2 == NOTCH2) begin
                    state2 <= wrap_inc(state2);
                    state3 <= wrap_inc(state3);
                end else if (state1 == NOTCH1) begin
                    state2 <= wrap_inc(state2);
                end
                settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end else if ((state == DRIVE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end
            if (capture) cipher_out <= ret_ok ? to_onehot(plug_ret) : '0;
        end
    end

endmodule

// File: tb/tb_enigma_key_sequencer.sv
// Directed bench for enigma_key_sequencer: vector table of keypresses plus
// hand-written programming, error, busy and reset sequences.
module tb_enigma_key_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [25:0] key_onehot;
    logic        prog_mode;
    logic        pos_load;
    logic [14:0] pos_init;
    logic [25:0] rero_in;
    logic [25:0] rero_out;
    logic [4:0]  state1, state2, state3;
    logic [25:0] cipher_out;
    logic        cipher_valid;
    logic        busy;
    logic [3:0]  pair_count;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    enigma_key_sequencer dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_onehot   (key_onehot),
        .prog_mode    (prog_mode),
        .pos_load     (pos_load),
        .pos_init     (pos_init),
        .rero_in      (rero_in),
        .rero_out     (rero_out),
        .state1       (state1),
        .state2       (state2),
        .state3       (state3),
        .cipher_out   (cipher_out),
        .cipher_valid (cipher_valid),
        .busy         (busy),
        .pair_count   (pair_count),
        .err          (err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic        load;
        logic [14:0] pos;
        logic [25:0] key;
        logic [25:0] ret;
        logic [25:0] rin;
        logic [25:0] cipher;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  s3;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_key(input logic [25:0] key);
        key_onehot = key;
        key_valid  = 1'b1;
        tick();
        key_valid  = 1'b0;
        key_onehot = '0;
    endtask

    task automatic load_pos(input logic [14:0] pos);
        pos_init = pos;
        pos_load = 1'b1;
        tick();
        pos_load = 1'b0;
    endtask

    // Latency counts clock edges from the one that samples key_valid.
    task automatic press(input string name, input logic [25:0] key, input logic [25:0] ret,
                         input logic [25:0] exp_rin, input logic [25:0] exp_c, input int inject_at);
        int          lat;
        logic        got;
        logic [25:0] rin_seen;
        rero_out = ret;
        send_key(key);
        lat      = 1;
        got      = 1'b0;
        rin_seen = '0;
        while (!got && lat < 20) begin
            if (lat == 3) rin_seen = rero_in;
            if (cipher_valid) begin
                got = 1'b1;
            end else begin
                if (lat == inject_at) begin
                    key_onehot = 26'h8;
                    key_valid  = 1'b1;
                end
                tick();
                lat++;
                if (key_valid) begin
                    key_valid  = 1'b0;
                    key_onehot = '0;
                    check({name, "_busy_err"}, err, 1);
                end
            end
        end
        check({name, "_latency"}, got ? lat : 0, 7);
        check({name, "_rero_in"}, rin_seen, exp_rin);
        check({name, "_cipher"}, cipher_out, exp_c);
        tick();
        check({name, "_valid_pulse"}, cipher_valid, 0);
    endtask

    initial begin
        logic        cv_seen;
        logic [4:0]  s1_save;
        logic [25:0] k;

        vecs[0] = '{1'b0, 15'd0,                      26'h1,       26'h10,      26'h1,       26'h10,      5'd1,  5'd0, 5'd0};
        vecs[1] = '{1'b1, {5'd0, 5'd3, 5'd16},        26'h2,       26'h4,       26'h2,       26'h4,       5'd17, 5'd4, 5'd0};
        vecs[2] = '{1'b0, 15'd0,                      26'h4,       26'h2000000, 26'h4,       26'h2000000, 5'd18, 5'd5, 5'd1};
        vecs[3] = '{1'b1, {5'd0, 5'd0, 5'd25},        26'h2000000, 26'h1,       26'h2000000, 26'h1,       5'd0,  5'd0, 5'd0};
        vecs[4] = '{1'b1, {5'd30, 5'd27, 5'd26},      26'h8,       26'h8,       26'h8,       26'h8,       5'd1,  5'd1, 5'd4};

        reset      = 1'b1;
        key_valid  = 1'b0;
        key_onehot = '0;
        prog_mode  = 1'b0;
        pos_load   = 1'b0;
        pos_init   = '0;
        rero_out   = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_state1", state1, 0);
        check("rst_state23", {state2, state3}, 0);
        check("rst_rero_in", rero_in, 0);
        check("rst_cipher", cipher_out, 0);
        check("rst_flags", {cipher_valid, err, busy}, 0);
        check("rst_pairs", pair_count, 0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].load) load_pos(vecs[i].pos);
            press($sformatf("vec%0d", i), vecs[i].key, vecs[i].ret, vecs[i].rin, vecs[i].cipher, 0);
            check($sformatf("vec%0d_state1", i), state1, vecs[i].s1);
            check($sformatf("vec%0d_state2", i), state2, vecs[i].s2);
            check($sformatf("vec%0d_state3", i), state3, vecs[i].s3);
        end

        // Program A-B, then A enciphers through the plugboard both ways.
        prog_mode = 1'b1;
        tick();
        send_key(26'h1);
        send_key(26'h2);
        prog_mode = 1'b0;
        tick();
        check("prog_ab_count", pair_count, 1);
        press("plug_ab", 26'h1, 26'h1, 26'h2, 26'h2, 0);
        check("plug_ab_state1", state1, 2);

        // Re-entry clears the table; A-A is rejected.
        prog_mode = 1'b1;
        tick();
        check("prog_clear", pair_count, 0);
        send_key(26'h1);
        check("prog_aa_first", err, 0);
        send_key(26'h1);
        check("prog_aa_err", err, 1);
        check("prog_aa_count", pair_count, 0);

        for (int i = 0; i < 10; i++) begin
            k = 26'd1 << (2 * i);
            send_key(k);
            send_key(k << 1);
            if (i == 0) begin
                send_key(26'h2);
                check("prog_plugged_err", err, 1);
            end
        end
        check("prog_ten_count", pair_count, 10);
        send_key(26'h100000);
        check("prog_full_err", err, 1);
        check("prog_full_count", pair_count, 10);
        prog_mode = 1'b0;
        tick();

        s1_save = state1;
        send_key(26'h3);
        check("bad_key_err", err, 1);
        tick();
        tick();
        check("bad_key_busy", busy, 0);
        check("bad_key_state", state1, s1_save);

        // Second key during DRIVE is dropped; first key completes normally.
        press("busy", 26'h100000, 26'h200000, 26'h100000, 26'h200000, 3);
        cv_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cipher_valid) cv_seen = 1'b1;
        end
        check("busy_no_extra_valid", cv_seen, 0);
        check("busy_state1", state1, 3);

        pos_init   = 15'd0;
        pos_load   = 1'b1;
        send_key(26'h1);
        pos_load   = 1'b0;
        check("load_key_err", err, 1);
        tick();
        check("load_key_busy", busy, 0);
        check("load_key_state1", state1, 0);

        // Reset in the middle of DRIVE.
        rero_out = 26'h4;
        send_key(26'h1);
        tick();
        tick();
        check("mid_drive_rero_in", rero_in, 26'h2);
        reset = 1'b1;
        #1;
        check("mid_rst_rero_in", rero_in, 0);
        check("mid_rst_cipher", cipher_out, 0);
        check("mid_rst_state1", state1, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pairs", pair_count, 0);
        tick();
        reset   = 1'b0;
        cv_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cipher_valid) cv_seen = 1'b1;
        end
        check("mid_rst_no_valid", cv_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
